// File: rtl/alt_compr_ctrl.sv
// alt_compr_ctrl: Moore controller for three compressors (C1..C3).
// Pressure inputs select stop / two-compressor / three-compressor operation.
// Two-compressor demands rotate through pairs C1C2 -> C1C3 -> C2C3 so that
// wear is spread evenly. Each idle state records which pair runs next.
module alt_compr_ctrl (
    input  logic Clk,
    input  logic Reset,
    input  logic PA,
    input  logic PB,
    input  logic PMB,
    output logic C1,
    output logic C2,
    output logic C3
);

    // A/D/F are idle states that remember the next pair. B runs all three.
    // C/E/G run pairs C1C2/C1C3/C2C3. Encoding 3'b111 is unused.
    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5,
        ST_G = 3'd6
    } state_t;

    state_t state;
    state_t next_state;

    // State register with synchronous reset to idle state A.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state <= ST_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection (PA > PMB > PB, otherwise hold) and output decode from state.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        next_state   = ST_A;
        {C1, C2, C3} = 3'b000;

        case (state)
            ST_A: begin
                {C1, C2, C3} = 3'b000;
                if (PA)       next_state = ST_A;
                else if (PMB) next_state = ST_B;
                else if (PB)  next_state = ST_C;
                else          next_state = ST_A;
            end
            ST_B: begin
                {C1, C2, C3} = 3'b111;
                // Leaving full demand always restarts the rotation at C1C2.
                if (PA) next_state = ST_A;
                else    next_state = ST_B;
            end
            ST_C: begin
                {C1, C2, C3} = 3'b110;
                if (PA)       next_state = ST_D;
                else if (PMB) next_state = ST_B;
                else          next_state = ST_C;
            end
            ST_D: begin
                {C1, C2, C3} = 3'b000;
                if (PA)       next_state = ST_D;
                else if (PMB) next_state = ST_B;
                else if (PB)  next_state = ST_E;
                else          next_state = ST_D;
            end
            ST_E: begin
                {C1, C2, C3} = 3'b101;
                if (PA)       next_state = ST_F;
                else if (PMB) next_state = ST_B;
                else          next_state = ST_E;
            end
            ST_F: begin
                {C1, C2, C3} = 3'b000;
                if (PA)       next_state = ST_F;
                else if (PMB) next_state = ST_B;
                else if (PB)  next_state = ST_G;
                else          next_state = ST_F;
            end
            ST_G: begin
                {C1, C2, C3} = 3'b011;
                if (PA)       next_state = ST_A;
                else if (PMB) next_state = ST_B;
                else          next_state = ST_G;
            end
            default: begin
                // Unused encoding: outputs off, recover to A.
                {C1, C2, C3} = 3'b000;
                next_state   = ST_A;
            end
        endcase
    end

endmodule

// File: tb/tb_alt_compr_ctrl.sv
// tb_alt_compr_ctrl: directed and randomized checks of alt_compr_ctrl
// against a mode/rotation-index reference model.
module tb_alt_compr_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic PA = 1'b0;
    logic PB = 1'b0;
    logic PMB = 1'b0;
    logic C1, C2, C3;

    int checks = 0;
    int errors = 0;

    // Reference model: operating mode plus index of the next/current pair.
    typedef enum {M_IDLE, M_ALL, M_PAIR} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_idx  = 0;

    alt_compr_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .PA    (PA),
        .PB    (PB),
        .PMB   (PMB),
        .C1    (C1),
        .C2    (C2),
        .C3    (C3)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2:0] model_out();
        logic [2:0] pairs [3];
        pairs[0] = 3'b110;
        pairs[1] = 3'b101;
        pairs[2] = 3'b011;
        case (m_mode)
            M_ALL:   return 3'b111;
            M_PAIR:  return pairs[m_idx];
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_update(input logic r, input logic pa, input logic pmb, input logic pb);
        if (r) begin
            m_mode = M_IDLE;
            m_idx  = 0;
        end else if (pa) begin
            if (m_mode == M_ALL) begin
                m_mode = M_IDLE;
                m_idx  = 0;
            end else if (m_mode == M_PAIR) begin
                m_mode = M_IDLE;
                m_idx  = (m_idx + 1) % 3;
            end
        end else if (pmb) begin
            m_mode = M_ALL;
        end else if (pb) begin
            if (m_mode == M_IDLE) m_mode = M_PAIR;
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare outputs after the edge.
    task automatic step(input logic r, input logic pa, input logic pmb, input logic pb, input string tag);
        logic [2:0] exp_v;
        logic [2:0] obs_v;
        Reset = r;
        PA    = pa;
        PMB   = pmb;
        PB    = pb;
        @(posedge Clk);
        model_update(r, pa, pmb, pb);
        #1;
        exp_v = model_out();
        obs_v = {C1, C2, C3};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: observed C=%b expected C=%b", tag, obs_v, exp_v);
        end
    endtask

    initial begin
        // Reset, then PA held: idle.
        step(1, 0, 0, 0, "reset");
        step(0, 1, 0, 0, "pa_idle_0");
        step(0, 1, 0, 0, "pa_idle_1");
        step(0, 1, 0, 0, "pa_idle_2");

        // Full demand from A and back.
        step(0, 0, 1, 0, "a_pmb_all");
        step(0, 1, 0, 0, "all_pa_idle");

        // Rotation through the three pairs.
        step(0, 0, 0, 1, "rot_c1c2");
        step(0, 1, 0, 0, "rot_idle_d");
        step(0, 0, 0, 1, "rot_c1c3");
        step(0, 1, 0, 0, "rot_idle_f");
        step(0, 0, 0, 1, "rot_c2c3");
        step(0, 1, 0, 0, "rot_idle_a");
        step(0, 0, 0, 1, "rot_wrap_c1c2");

        // Full demand from each of C/D/E/F/G, then rotation restart.
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 0, 0, "fd_reset");
            for (int j = 0; j < k; j++) begin
                if (j % 2 == 0) step(0, 0, 0, 1, "fd_walk_pb");
                else            step(0, 1, 0, 0, "fd_walk_pa");
            end
            step(0, 0, 1, 0, "fd_pmb_all");
            step(0, 1, 0, 0, "fd_pa_idle");
            step(0, 0, 0, 1, "fd_pb_restart");
        end

        // Priority: PA beats PMB in E.
        step(1, 0, 0, 0, "prio_reset");
        step(0, 0, 0, 1, "prio_c");
        step(0, 1, 0, 0, "prio_d");
        step(0, 0, 0, 1, "prio_e");
        step(0, 1, 1, 0, "prio_pa_pmb_f");
        step(0, 0, 0, 1, "prio_g");
        step(0, 1, 1, 1, "prio_all_inputs");

        // Hold in C, then reset with PB asserted.
        step(1, 0, 0, 0, "hold_reset");
        step(0, 0, 0, 1, "hold_c");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "hold_c_idle_in");
        step(0, 0, 1, 0, "hold_to_all");
        step(1, 0, 0, 1, "reset_with_pb");
        step(0, 0, 0, 1, "after_reset_pb");

        // Randomized stimulus with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
